// File: rtl/avm_write_control_if.sv
// Avalon-MM write-side signal bundle between the burst write master and the
// SDRAM controller slave port.
interface avm_write_control_if;
  logic        avl_wait_req_in;
  logic        avl_write_out;
  logic [7:0]  avl_size_out;
  logic [24:0] avl_addr_out;
  logic [15:0] avl_wdata_out;

  modport master (
    input  avl_wait_req_in,
    output avl_write_out,
    output avl_size_out,
    output avl_addr_out,
    output avl_wdata_out
  );

  modport slave (
    output avl_wait_req_in,
    input  avl_write_out,
    input  avl_size_out,
    input  avl_addr_out,
    input  avl_wdata_out
  );
endinterface

// File: rtl/avm_write_control.sv
// Avalon-MM burst write master: one rising edge on start_trigger writes a
// fixed-length burst of an incrementing 16-bit pattern starting at SEED.
module avm_write_control #(
  parameter int unsigned BURST_SIZE = 32,
  parameter logic [24:0] BASE_ADDR  = 25'd0,
  parameter logic [15:0] SEED       = 16'h0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_trigger,
  avm_write_control_if.master avm,
  output logic                busy_out,
  output logic                done_out
);

  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_SET   = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;

  localparam logic [7:0] CNT_INIT = 8'(BURST_SIZE - 1);

  logic       meta_reg;
  logic       s1_reg;
  logic       s2_reg;
  logic       det;

  logic [1:0]  state_reg;
  logic        write_reg;
  logic [15:0] wdata_reg;
  logic [7:0]  beat_cnt_reg;
  logic        done_reg;
  logic        accept;

  // meta/s1 resynchronise the trigger; s2 is the delayed copy for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= 1'b0;
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
    end else begin
      meta_reg <= start_trigger;
      s1_reg   <= meta_reg;
      s2_reg   <= s1_reg;
    end
  end

  assign det    = s1_reg & ~s2_reg;
  assign accept = write_reg & ~avm.avl_wait_req_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= WR_IDLE;
      write_reg    <= 1'b0;
      wdata_reg    <= SEED;
      beat_cnt_reg <= CNT_INIT;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        WR_IDLE: begin
          if (det) begin
            state_reg <= WR_SET;
          end
        end
        WR_SET: begin
          write_reg    <= 1'b1;
          wdata_reg    <= SEED;
          beat_cnt_reg <= CNT_INIT;
          state_reg    <= WR_BURST;
        end
        WR_BURST: begin
          // Stalled beats keep write and data untouched
          if (accept) begin
            if (beat_cnt_reg != 8'd0) begin
              beat_cnt_reg <= beat_cnt_reg - 8'd1;
              wdata_reg    <= wdata_reg + 16'd1;
            end else begin
              write_reg <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= WR_IDLE;
            end
          end
        end
        default: begin
          state_reg <= WR_IDLE;
          write_reg <= 1'b0;
        end
      endcase
    end
  end

  assign avm.avl_write_out = write_reg;
  assign avm.avl_wdata_out = wdata_reg;
  assign avm.avl_size_out  = 8'(BURST_SIZE);
  assign avm.avl_addr_out  = BASE_ADDR;
  assign busy_out          = (state_reg != WR_IDLE);
  assign done_out          = done_reg;

endmodule

// File: tb/tb_avm_write_control.sv
// Scoreboard bench for avm_write_control: three instances (32-beat default,
// 1-beat and 2-beat wrap variants) checked by a common negedge monitor.
module tb_avm_write_control;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic clk;
  logic reset_n;

  logic        start    [3];
  logic        wait_req [3];
  logic        write_w  [3];
  logic [15:0] wdata_w  [3];
  logic [7:0]  size_w   [3];
  logic [24:0] addr_w   [3];
  logic        busy_w   [3];
  logic        done_w   [3];

  beat_t exp_q [3][$];
  int    len_q [3][$];
  int    stall_cnt [256];

  int checks   = 0;
  int failures = 0;

  avm_write_control_if bus0 ();
  avm_write_control_if bus1 ();
  avm_write_control_if bus2 ();

  avm_write_control #(.BURST_SIZE(32), .BASE_ADDR(25'd0), .SEED(16'h0000)) dut0 (
    .clk(clk), .reset_n(reset_n), .start_trigger(start[0]), .avm(bus0),
    .busy_out(busy_w[0]), .done_out(done_w[0])
  );
  avm_write_control #(.BURST_SIZE(1), .BASE_ADDR(25'h1ABCDE), .SEED(16'hFFFF)) dut1 (
    .clk(clk), .reset_n(reset_n), .start_trigger(start[1]), .avm(bus1),
    .busy_out(busy_w[1]), .done_out(done_w[1])
  );
  avm_write_control #(.BURST_SIZE(2), .BASE_ADDR(25'h1ABCDE), .SEED(16'hFFFF)) dut2 (
    .clk(clk), .reset_n(reset_n), .start_trigger(start[2]), .avm(bus2),
    .busy_out(busy_w[2]), .done_out(done_w[2])
  );

  assign bus0.avl_wait_req_in = wait_req[0];
  assign bus1.avl_wait_req_in = wait_req[1];
  assign bus2.avl_wait_req_in = wait_req[2];
  assign write_w[0] = bus0.avl_write_out;
  assign write_w[1] = bus1.avl_write_out;
  assign write_w[2] = bus2.avl_write_out;
  assign wdata_w[0] = bus0.avl_wdata_out;
  assign wdata_w[1] = bus1.avl_wdata_out;
  assign wdata_w[2] = bus2.avl_wdata_out;
  assign size_w[0]  = bus0.avl_size_out;
  assign size_w[1]  = bus1.avl_size_out;
  assign size_w[2]  = bus2.avl_size_out;
  assign addr_w[0]  = bus0.avl_addr_out;
  assign addr_w[1]  = bus1.avl_addr_out;
  assign addr_w[2]  = bus2.avl_addr_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] seed_of(input int i);
    return (i == 0) ? 16'h0000 : 16'hFFFF;
  endfunction

  function automatic int bs_of(input int i);
    case (i)
      0:       return 32;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [24:0] addr_of(input int i);
    return (i == 0) ? 25'd0 : 25'h1ABCDE;
  endfunction

  task automatic check(input bit ok, input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s dut%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  // Monitor: pops expected beats on every accept, checks done timing,
  // burst length and data stability during waitrequest stalls.
  initial begin
    bit          exp_done   [3];
    int          wcyc       [3];
    bit          stall_prev [3];
    logic [15:0] stall_data [3];
    beat_t       b;
    int          len;
    for (int i = 0; i < 3; i++) begin
      exp_done[i] = 1'b0; wcyc[i] = 0; stall_prev[i] = 1'b0; stall_data[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!reset_n) begin
          exp_done[i] = 1'b0; wcyc[i] = 0; stall_prev[i] = 1'b0;
          continue;
        end
        if (done_w[i] || exp_done[i]) begin
          check(done_w[i] == exp_done[i], "done_pulse", i, 32'(done_w[i]), 32'(exp_done[i]));
          if (done_w[i]) begin
            check(write_w[i] == 1'b0, "done_write_low", i, 32'(write_w[i]), 32'd0);
            if (len_q[i].size() == 0) begin
              check(1'b0, "burst_len_unexpected", i, wcyc[i], 32'd0);
            end else begin
              len = len_q[i].pop_front();
              check(wcyc[i] == len, "burst_len", i, wcyc[i], len);
            end
            $display("burst dut%0d complete write_cycles=%0d", i, wcyc[i]);
            wcyc[i] = 0;
          end
        end
        exp_done[i] = 1'b0;
        if (stall_prev[i] && write_w[i])
          check(wdata_w[i] == stall_data[i], "stall_hold", i, wdata_w[i], stall_data[i]);
        if (write_w[i]) begin
          wcyc[i]++;
          if (!wait_req[i]) begin
            stall_prev[i] = 1'b0;
            if (exp_q[i].size() == 0) begin
              check(1'b0, "unexpected_beat", i, wdata_w[i], 32'd0);
            end else begin
              b = exp_q[i].pop_front();
              check(wdata_w[i] == b.data, "beat_data", i, wdata_w[i], b.data);
              check(addr_w[i] == addr_of(i) && size_w[i] == 8'(bs_of(i)),
                    "beat_addr_size", i, {addr_w[i], 7'd0} | 32'(size_w[i]),
                    {addr_of(i), 7'd0} | 32'(bs_of(i)));
              exp_done[i] = b.last;
            end
          end else begin
            stall_prev[i] = 1'b1;
            stall_data[i] = wdata_w[i];
          end
        end else begin
          stall_prev[i] = 1'b0;
        end
      end
    end
  end

  // One trigger pulse and its burst; retrig_beat re-pulses start during that
  // beat, rst_beat asserts reset_n while that beat is presented.
  task automatic run_burst(input int idx, input int retrig_beat, input int rst_beat);
    int    n;
    int    total;
    beat_t e;
    bit    aborted;
    n       = bs_of(idx);
    total   = n;
    aborted = 1'b0;
    for (int b = 0; b < n; b++) total += stall_cnt[b];
    for (int b = 0; b < n; b++) begin
      e.data = 16'(seed_of(idx) + 16'(b));
      e.last = (b == n - 1);
      exp_q[idx].push_back(e);
    end
    if (rst_beat < 0) len_q[idx].push_back(total);
    @(posedge clk); #1 start[idx] = 1'b1;
    @(posedge clk); #1 start[idx] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check(busy_w[idx] && !write_w[idx], "latency_set", idx,
          {30'd0, busy_w[idx], write_w[idx]}, 32'h2);
    @(posedge clk); #1;
    check(write_w[idx] == 1'b1, "latency_write", idx, 32'(write_w[idx]), 32'd1);
    for (int b = 0; b < n; b++) begin
      if (b == rst_beat) begin
        reset_n = 1'b0;
        #1;
        check(write_w[idx] == 1'b0, "reset_write_drop", idx, 32'(write_w[idx]), 32'd0);
        check(done_w[idx] == 1'b0, "reset_no_done", idx, 32'(done_w[idx]), 32'd0);
        exp_q[idx].delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      start[idx] = (b == retrig_beat);
      for (int s = 0; s < stall_cnt[b]; s++) begin
        wait_req[idx] = 1'b1;
        @(posedge clk); #1;
      end
      wait_req[idx] = 1'b0;
      @(posedge clk); #1;
    end
    start[idx] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    if (!aborted)
      check(busy_w[idx] == 1'b0, "idle_after_burst", idx, 32'(busy_w[idx]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog dut0 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      wait_req[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) stall_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check(write_w[i] == 1'b0, "reset_write", i, 32'(write_w[i]), 32'd0);
      check(done_w[i] == 1'b0, "reset_done", i, 32'(done_w[i]), 32'd0);
      check(busy_w[i] == 1'b0, "reset_busy", i, 32'(busy_w[i]), 32'd0);
      check(wdata_w[i] == seed_of(i), "reset_wdata", i, wdata_w[i], seed_of(i));
      check(addr_w[i] == addr_of(i), "reset_addr", i, addr_w[i], addr_of(i));
      check(size_w[i] == 8'(bs_of(i)), "reset_size", i, size_w[i], bs_of(i));
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain 32-beat burst, waitrequest tied low
    run_burst(0, -1, -1);

    // Stalls on beats 0, 5 (three cycles) and 31: 37 write cycles
    stall_cnt[0] = 1; stall_cnt[5] = 3; stall_cnt[31] = 1;
    run_burst(0, -1, -1);
    stall_cnt[0] = 0; stall_cnt[5] = 0; stall_cnt[31] = 0;

    // Trigger held high for 200 cycles gives a single burst
    for (int b = 0; b < 32; b++) begin
      beat_t e;
      e.data = 16'(b);
      e.last = (b == 31);
      exp_q[0].push_back(e);
    end
    len_q[0].push_back(32);
    @(posedge clk); #1 start[0] = 1'b1;
    repeat (200) @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check(exp_q[0].size() == 0, "held_trigger_drain", 0, exp_q[0].size(), 32'd0);

    // Second edge mid-burst is dropped; next edge after done works from SEED
    run_burst(0, 10, -1);
    run_burst(0, -1, -1);

    // Reset at beat 15 abandons the burst; a fresh full burst follows
    run_burst(0, -1, 15);
    run_burst(0, -1, -1);

    // Single-beat and two-beat wrap variants
    run_burst(1, -1, -1);
    run_burst(2, -1, -1);

    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check(exp_q[i].size() == 0, "beats_outstanding", i, exp_q[i].size(), 32'd0);
      check(len_q[i].size() == 0, "bursts_outstanding", i, len_q[i].size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
